bfm_apb_slave: RTL and testbench

APB3 completer bus-functional model: the responder end of the APB initiator BFM. It sits on the APB segment of block-level testbenches in place of a real peripheral and provides:
- a word-addressed memory,
- programmable wait states,
- PSLVERR injection,
- transfer counters,
- a sticky protocol-violation monitor for checking the initiator.

---
 rtl/bfm_apb_pkg.sv | 15 +
 rtl/bfm_apb_slave_mem.sv | 26 ++
 rtl/bfm_apb_slave.sv | 139 +++++++++++++
 tb/tb_bfm_apb_slave.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bfm_apb_pkg.sv
// Shared types and constants for the APB3 completer BFM.
package bfm_apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam logic [APB_AW-1:0] DEF_BASE_ADDR = 32'h0000_0000;
  localparam logic [APB_AW-1:0] DEF_ERR_ADDR  = 32'hFFFF_FFFC;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/bfm_apb_slave_mem.sv
// Word memory for the APB completer BFM: synchronous write, combinational read.
// Contents start at zero and are deliberately untouched by bus reset.
module bfm_apb_slave_mem
  import bfm_apb_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [APB_DW-1:0] wdata,
  output logic [APB_DW-1:0] rdata
);

  logic [APB_DW-1:0] mem_q [MEM_DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/bfm_apb_slave.sv
// APB3 completer BFM: memory, wait states, PSLVERR decode, counters, protocol monitor.
// state  | meaning
// IDLE   | no transfer; setup phase moves to ACCESS and captures the request
// ACCESS | counting wait states; leaves on PREADY or on a dropped PSEL/PENABLE
module bfm_apb_slave
  import bfm_apb_pkg::*;
#(
  parameter int                MEM_DEPTH = 256,
  parameter logic [APB_AW-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [APB_AW-1:0] ERR_ADDR  = DEF_ERR_ADDR,
  parameter int                CNT_WIDTH = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic [APB_AW-1:0]    PADDR,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [APB_DW-1:0]    PWDATA,
  output logic [APB_DW-1:0]    PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [3:0]           WAIT_CYCLES,
  output logic [CNT_WIDTH-1:0] WR_COUNT,
  output logic [CNT_WIDTH-1:0] RD_COUNT,
  output logic                 PROT_ERR
);

  localparam int          IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] SPAN  = 33'(MEM_DEPTH) << 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [APB_AW-1:0]      addr_q, addr_d;
  logic                   write_q, write_d;
  logic [APB_DW-1:0]      wdata_q, wdata_d;
  logic [3:0]             wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic                   prot_err_q, prot_err_d;

  logic [APB_AW-1:0]      offset;
  logic                   addr_err;
  logic                   access_ok;
  logic                   pready;
  logic                   mem_we;
  logic [APB_DW-1:0]      mem_rdata;

  // Decode runs on the captured address so the response cannot follow a misbehaving PADDR.
  assign offset    = addr_q - BASE_ADDR;
  assign addr_err  = (addr_q < BASE_ADDR) || ({1'b0, offset} >= SPAN) ||
                     (addr_q[1:0] != 2'b00) || (addr_q == ERR_ADDR);
  assign access_ok = (state_q == ST_ACCESS) && PSEL && PENABLE;
  assign pready    = access_ok && (wait_q == 4'd0);
  assign mem_we    = pready && write_q && !addr_err && !PRESET;

  assign PREADY   = pready;
  assign PSLVERR  = pready && addr_err;
  assign PRDATA   = ((state_q == ST_ACCESS) && !write_q && !addr_err) ? mem_rdata : '0;
  assign WR_COUNT = wr_cnt_q;
  assign RD_COUNT = rd_cnt_q;
  assign PROT_ERR = prot_err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    prot_err_d = prot_err_q;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          wait_d  = WAIT_CYCLES;
        end else if (PSEL && PENABLE) begin
          prot_err_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if ((PADDR != addr_q) || (PWRITE != write_q) || (write_q && (PWDATA != wdata_q))) begin
          prot_err_d = 1'b1;
        end
        if (!access_ok) begin
          prot_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
          if (!addr_err) begin
            if (write_q && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (!write_q && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      prot_err_q <= prot_err_d;
    end
  end

  bfm_apb_slave_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .we    (mem_we),
    .idx   (offset[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_bfm_apb_slave.sv
// Directed bench for the APB completer BFM; counters built 4 bits wide to reach saturation.
module tb_bfm_apb_slave;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  WAIT_CYCLES;
  logic [3:0]  WR_COUNT;
  logic [3:0]  RD_COUNT;
  logic        PROT_ERR;

  int n_chk = 0;
  int n_bad = 0;

  bfm_apb_slave #(
    .MEM_DEPTH (256),
    .BASE_ADDR (32'h0000_0000),
    .ERR_ADDR  (32'hFFFF_FFFC),
    .CNT_WIDTH (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .PSEL        (PSEL),
    .PADDR       (PADDR),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .WAIT_CYCLES (WAIT_CYCLES),
    .WR_COUNT    (WR_COUNT),
    .RD_COUNT    (RD_COUNT),
    .PROT_ERR    (PROT_ERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Full setup+access transfer; call and return at 1 time unit after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [3:0] ws_after,
                      output logic [31:0] rd, output logic err, output int acc);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; WAIT_CYCLES = ws;
    tick();
    PENABLE = 1'b1;
    WAIT_CYCLES = ws_after;
    #1;
    acc = 1;
    while (!PREADY && acc < 40) begin
      tick();
      acc++;
    end
    rd  = PRDATA;
    err = PSLVERR;
    if (!PREADY) chk("ready_timeout", 32'(PREADY), 32'd1);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          acc;

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; WAIT_CYCLES = '0;
    repeat (3) tick();
    PRESET = 1'b0;
    #1;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_wr_count", 32'(WR_COUNT), 32'd0);
    chk("rst_rd_count", 32'(RD_COUNT), 32'd0);
    chk("rst_prot_err", 32'(PROT_ERR), 32'd0);
    tick();

    // basic write then read, no waits
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'd0, 4'd0, rd, err, acc);
    chk("w10_acc", 32'(acc), 32'd1);
    chk("w10_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'd0, 4'd0, rd, err, acc);
    chk("r10_acc", 32'(acc), 32'd1);
    chk("r10_data", rd, 32'hDEADBEEF);
    chk("r10_err", 32'(err), 32'd0);
    chk("wr_count_1", 32'(WR_COUNT), 32'd1);
    chk("rd_count_1", 32'(RD_COUNT), 32'd1);

    // three waits, WAIT_CYCLES dropped to 0 once access starts
    xfer(1'b0, 32'h20, 32'h0, 4'd3, 4'd0, rd, err, acc);
    chk("r20_acc", 32'(acc), 32'd4);
    chk("r20_data", rd, 32'h0);
    chk("rd_count_2", 32'(RD_COUNT), 32'd2);

    // error responses leave memory and WR_COUNT alone
    xfer(1'b1, 32'h0, 32'hA5A5_0000, 4'd0, 4'd0, rd, err, acc);
    chk("w0_err", 32'(err), 32'd0);
    chk("wr_count_2", 32'(WR_COUNT), 32'd2);
    xfer(1'b1, 32'h400, 32'h1234, 4'd0, 4'd0, rd, err, acc);
    chk("w400_err", 32'(err), 32'd1);
    chk("w400_acc", 32'(acc), 32'd1);
    xfer(1'b1, 32'h2, 32'h1234, 4'd0, 4'd0, rd, err, acc);
    chk("w02_err", 32'(err), 32'd1);
    xfer(1'b1, 32'hFFFF_FFFC, 32'h1234, 4'd0, 4'd0, rd, err, acc);
    chk("werraddr_err", 32'(err), 32'd1);
    chk("wr_count_err", 32'(WR_COUNT), 32'd2);
    xfer(1'b0, 32'h0, 32'h0, 4'd0, 4'd0, rd, err, acc);
    chk("r0_data", rd, 32'hA5A5_0000);
    chk("r0_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h3FC, 32'h0, 4'd0, 4'd0, rd, err, acc);
    chk("r3fc_err", 32'(err), 32'd0);
    chk("prot_clean", 32'(PROT_ERR), 32'd0);

    // access without setup
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h10; PWRITE = 1'b0;
    tick();
    chk("prot_nosetup", 32'(PROT_ERR), 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) tick();
    chk("prot_held", 32'(PROT_ERR), 32'd1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("prot_cleared", 32'(PROT_ERR), 32'd0);

    // PADDR moves during a waited access
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h20; WAIT_CYCLES = 4'd2;
    tick();
    PENABLE = 1'b1;
    #1;
    chk("prot_pre_move", 32'(PROT_ERR), 32'd0);
    tick();
    PADDR = 32'h24;
    tick();
    chk("prot_addr_move", 32'(PROT_ERR), 32'd1);
    PADDR = 32'h20;
    #1;
    acc = 0;
    while (!PREADY && acc < 40) begin
      tick();
      acc++;
    end
    if (!PREADY) chk("ready_timeout_move", 32'(PREADY), 32'd1);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) tick();
    chk("prot_move_held", 32'(PROT_ERR), 32'd1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("prot_move_cleared", 32'(PROT_ERR), 32'd0);

    // reset in the middle of a 5-wait write
    xfer(1'b1, 32'h8, 32'h1111_2222, 4'd0, 4'd0, rd, err, acc);
    chk("w8_pre_count", 32'(WR_COUNT), 32'd1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8; PWDATA = 32'h9999_9999;
    WAIT_CYCLES = 4'd5;
    tick();
    PENABLE = 1'b1;
    repeat (2) tick();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    #1;
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_wr_count", 32'(WR_COUNT), 32'd0);
    chk("midrst_rd_count", 32'(RD_COUNT), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    chk("midrst_prot", 32'(PROT_ERR), 32'd0);
    xfer(1'b0, 32'h8, 32'h0, 4'd0, 4'd0, rd, err, acc);
    chk("r8_kept", rd, 32'h1111_2222);
    chk("r8_acc", 32'(acc), 32'd1);

    // saturation of the 4-bit read counter
    for (int i = 0; i < 13; i++) xfer(1'b0, 32'h10, 32'h0, 4'd0, 4'd0, rd, err, acc);
    chk("rd_count_14", 32'(RD_COUNT), 32'd14);
    for (int i = 0; i < 3; i++) xfer(1'b0, 32'h10, 32'h0, 4'd0, 4'd0, rd, err, acc);
    chk("rd_count_sat", 32'(RD_COUNT), 32'hF);
    chk("sat_data", rd, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
